// File: rtl/rng_share_arb.sv
// Shares one RNG core among NREQ consumers: keeps one prefetched word, grants it
// round-robin, supervises the RNG handshake with timeout/retry, and supports a flush.
module rng_share_arb #(
  parameter int NREQ    = 3,
  parameter int RNG_W   = 96,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clear,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [RNG_W-1:0] rd_data,
  output logic             rng_start,
  input  logic             rng_finish,
  input  logic [RNG_W-1:0] rng_data,
  output logic             buf_valid,
  output logic             err_timeout,
  output logic             err_spurious
);

  localparam int              IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W:0]  NREQ_L  = (IDX_W+1)'(NREQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);

  typedef enum logic [1:0] {S_PRIME, S_WAIT, S_FULL} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] winner;
  logic [TO_W-1:0]  cnt;
  logic             drop;
  logic [RNG_W-1:0] buffer;

  // Rotate the request vector so the rr pointer sits at bit 0, take the lowest set bit.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*NREQ-1:0] rot;
    logic [IDX_W-1:0]  off;
    logic [IDX_W:0]    sum;
    rot = {r, r} >> ptr;
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_L) sum = sum - NREQ_L;
    return sum[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w);
    logic [IDX_W:0] n;
    n = {1'b0, w} + (IDX_W+1)'(1);
    return (n == NREQ_L) ? '0 : n[IDX_W-1:0];
  endfunction

  assign winner = rr_pick(req, rr);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= S_PRIME;
      ack          <= '0;
      rd_data      <= '0;
      rng_start    <= 1'b0;
      buf_valid    <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      rr           <= '0;
      cnt          <= '0;
      drop         <= 1'b0;
    end else begin
      ack       <= '0;
      rng_start <= 1'b0;
      if (clear) begin
        buf_valid    <= 1'b0;
        err_timeout  <= 1'b0;
        err_spurious <= 1'b0;
        rr           <= '0;
        // An operation in flight cannot be cancelled; mark its word for discard.
        if (state == S_WAIT && !rng_finish) begin
          drop <= 1'b1;
          if (cnt == TO_LAST) begin
            rng_start <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end else begin
          drop  <= 1'b0;
          state <= S_PRIME;
        end
      end else begin
        case (state)
          S_PRIME: begin
            if (rng_finish) err_spurious <= 1'b1;
            rng_start <= 1'b1;
            cnt       <= '0;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            if (rng_finish) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_PRIME;
              end else begin
                buf_valid <= 1'b1;
                state     <= S_FULL;
              end
            end else if (cnt == TO_LAST) begin
              rng_start   <= 1'b1;
              cnt         <= '0;
              err_timeout <= 1'b1;
            end else begin
              cnt <= cnt + TO_W'(1);
            end
          end
          S_FULL: begin
            if (rng_finish) err_spurious <= 1'b1;
            // Grant and refill on the same edge so the buffer is never idle.
            if (|req) begin
              ack       <= ONE << winner;
              rd_data   <= buffer;
              buf_valid <= 1'b0;
              rng_start <= 1'b1;
              cnt       <= '0;
              rr        <= rr_next(winner);
              state     <= S_WAIT;
            end
          end
          default: state <= S_PRIME;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WAIT && rng_finish && !clear && !drop) buffer <= rng_data;
  end

endmodule

// File: tb/tb_rng_share_arb.sv
// Bench for rng_share_arb: directed scenarios plus randomized requests and RNG latency,
// with a scoreboard of delivered RNG words and a round-robin reference.
module tb_rng_share_arb;

  localparam int NREQ    = 3;
  localparam int RNG_W   = 96;
  localparam int TIMEOUT = 255;
  localparam int TO_W    = 8;

  logic             clk   = 1'b0;
  logic             rst_b = 1'b0;
  logic             clear = 1'b0;
  logic [NREQ-1:0]  req   = '0;
  logic [NREQ-1:0]  ack;
  logic [RNG_W-1:0] rd_data;
  logic             rng_start;
  logic             rng_finish;
  logic [RNG_W-1:0] rng_data;
  logic             buf_valid;
  logic             err_timeout;
  logic             err_spurious;

  logic             auto_rng  = 1'b0;
  logic             auto_fin  = 1'b0;
  logic             man_fin   = 1'b0;
  logic [RNG_W-1:0] auto_data = '0;
  logic [RNG_W-1:0] man_data  = '0;

  assign rng_finish = auto_fin | man_fin;
  assign rng_data   = auto_fin ? auto_data : man_data;

  int checks = 0;
  int errors = 0;
  logic [RNG_W-1:0] word_q[$];

  rng_share_arb #(.NREQ(NREQ), .RNG_W(RNG_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_b(rst_b), .clear(clear), .req(req), .ack(ack), .rd_data(rd_data),
    .rng_start(rng_start), .rng_finish(rng_finish), .rng_data(rng_data),
    .buf_valid(buf_valid), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural RNG core: answers each observed rng_start after a random latency.
  initial begin : responder
    int d;
    forever begin
      @(negedge clk);
      if (auto_rng && rst_b && rng_start) begin
        d = $urandom_range(0, 12);
        repeat (d) @(negedge clk);
        auto_data = {$urandom, $urandom, $urandom};
        auto_fin  = 1'b1;
        word_q.push_back(auto_data);
        @(negedge clk);
        auto_fin = 1'b0;
      end
    end
  end

  // Monitor: predicts every grant from the requests seen at the edge.
  initial begin : monitor
    logic             prev_bv;
    logic             prev_start;
    int               rr_m;
    int               w;
    int               idx;
    logic [RNG_W-1:0] exp_w;
    prev_bv = 1'b0; prev_start = 1'b0; rr_m = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_b) begin
        prev_bv = 1'b0; prev_start = 1'b0; rr_m = 0;
        word_q.delete();
      end else begin
        if (rng_start) chk("rng_start_back_to_back", prev_start, 1'b0);
        if (prev_bv && req != '0 && !clear) begin
          w = -1;
          for (int k = 0; k < NREQ; k++) begin
            idx = (rr_m + k) % NREQ;
            if (w < 0 && req[idx]) w = idx;
          end
          chk("grant_onehot", ack, 1 << w);
          chk("grant_refill_start", rng_start, 1'b1);
          if (word_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_data: ack with no word delivered by the RNG, got %0h", rd_data);
          end else begin
            exp_w = word_q.pop_front();
            chk("rd_data", rd_data, exp_w);
          end
          rr_m = (w + 1) % NREQ;
        end else begin
          chk("no_grant", ack, '0);
        end
        if (clear) begin
          rr_m = 0;
          word_q.delete();
        end
        prev_bv    = buf_valid;
        prev_start = rng_start;
      end
    end
  end

  initial begin : watchdog
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int               n;
    int               na;
    logic [RNG_W-1:0] w_saved;
    logic [NREQ-1:0]  acks[4];
    acks = '{default: '0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {ack, rng_start, buf_valid, err_timeout, err_spurious}, '0);
    chk("reset_rd_data", rd_data, '0);
    rst_b = 1'b1;

    // First fill: finish five cycles after the priming start.
    n = 0;
    do begin @(negedge clk); n++; end while (!rng_start && n < 10);
    chk("prime_start", rng_start, 1'b1);
    repeat (4) @(negedge clk);
    man_data = {12{8'hA5}};
    man_fin  = 1'b1;
    word_q.push_back(man_data);
    @(negedge clk);
    man_fin = 1'b0;
    chk("t1_buf_valid", buf_valid, 1'b1);
    chk("t1_no_ack", ack, '0);
    repeat (3) @(negedge clk);
    chk("t1_hold_full", {buf_valid, ack}, {1'b1, {NREQ{1'b0}}});

    // All requesters held high: round-robin order.
    auto_rng = 1'b1;
    req      = '1;
    n = 0; na = 0;
    while (na < 4 && n < 200) begin
      @(negedge clk); n++;
      if (ack != '0) begin
        acks[na] = ack;
        chk("t2_start_with_ack", rng_start, 1'b1);
        na++;
      end
    end
    req = '0;
    chk("t2_ack0", acks[0], 3'b001);
    chk("t2_ack1", acks[1], 3'b010);
    chk("t2_ack2", acks[2], 3'b100);
    chk("t2_ack3", acks[3], 3'b001);
    n = 0;
    while (!buf_valid && n < 50) begin @(negedge clk); n++; end
    auto_rng = 1'b0;
    chk("t2_refill", buf_valid, 1'b1);

    // Spurious finish while full leaves the buffer intact.
    repeat (2) @(negedge clk);
    chk("t5_word_pending", word_q.size(), 1);
    w_saved  = (word_q.size() > 0) ? word_q[0] : '0;
    man_data = {24{4'hD}};
    man_fin  = 1'b1;
    @(negedge clk);
    man_fin = 1'b0;
    chk("t5_spurious_flag", err_spurious, 1'b1);
    chk("t5_buf_kept", buf_valid, 1'b1);
    req = NREQ'(2);
    @(negedge clk);
    req = '0;
    chk("t5_ack", ack, NREQ'(2));
    chk("t5_buffer_unchanged", rd_data, w_saved);

    // Flush while an operation is outstanding.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t4_clear_flags", {err_spurious, err_timeout, buf_valid}, '0);
    man_data = 96'h1234;
    man_fin  = 1'b1;
    @(negedge clk);
    man_fin = 1'b0;
    chk("t4_dropped", buf_valid, 1'b0);
    chk("t4_no_start_yet", rng_start, 1'b0);
    @(negedge clk);
    chk("t4_restart", rng_start, 1'b1);
    man_data = {$urandom, $urandom, $urandom};
    w_saved  = man_data;
    man_fin  = 1'b1;
    word_q.push_back(man_data);
    @(negedge clk);
    man_fin = 1'b0;
    chk("t4_refill", buf_valid, 1'b1);
    req = NREQ'(5);
    @(negedge clk);
    req = '0;
    chk("t4_rr_reset_ack", ack, NREQ'(1));
    chk("t4_fresh_word", rd_data, w_saved);

    // Stalled RNG: periodic retries.
    chk("t3_no_err_yet", err_timeout, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rng_start && n < 400);
    chk("t3_retry_period", n, TIMEOUT);
    chk("t3_err_timeout", err_timeout, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!rng_start && n < 400);
    chk("t3_retry_period2", n, TIMEOUT);
    repeat (7) @(negedge clk);
    man_data = {$urandom, $urandom, $urandom};
    man_fin  = 1'b1;
    word_q.push_back(man_data);
    @(negedge clk);
    man_fin = 1'b0;
    chk("t3_late_finish", buf_valid, 1'b1);
    chk("t3_err_sticky", err_timeout, 1'b1);

    // Asynchronous reset in the middle of a refill.
    req = NREQ'(2);
    @(negedge clk);
    chk("t6_ack", ack, NREQ'(2));
    repeat (3) @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk("t6_async_reset", {ack, rng_start, buf_valid, err_timeout, err_spurious}, '0);
    chk("t6_async_rd_data", rd_data, '0);
    auto_rng = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rng_start && ack == '0 && n < 10);
    chk("t6_prime_first", {rng_start, ack}, {1'b1, {NREQ{1'b0}}});
    n = 0;
    while (ack == '0 && n < 50) begin @(negedge clk); n++; end
    chk("t6_served_after_prime", ack, NREQ'(2));

    // Randomized requests against the randomized RNG latency.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
    end
    req = '0;
    n = 0;
    while (!buf_valid && n < 50) begin @(negedge clk); n++; end
    auto_rng = 1'b0;
    chk("rand_refill", buf_valid, 1'b1);
    chk("rand_no_errors", {err_timeout, err_spurious}, '0);
    repeat (3) @(negedge clk);
    chk("rand_one_word_buffered", word_q.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
